// File: rtl/line_burst_adapter_if.sv
// Cache-side line port and memory-side burst port of the line/burst adapter.
// The adapter takes the slave view; the cache/memory environment takes the master view.
interface line_burst_adapter_if #(
    parameter int S_LINE  = 256,
    parameter int S_BURST = 64
);
    logic                line_read;
    logic                line_write;
    logic [31:0]         line_address;
    logic [S_LINE-1:0]   line_wdata;
    logic [S_LINE-1:0]   line_rdata;
    logic                line_resp;
    logic                mem_read;
    logic                mem_write;
    logic [31:0]         mem_address;
    logic [S_BURST-1:0]  mem_wdata;
    logic [S_BURST-1:0]  mem_rdata;
    logic                mem_resp;

    modport slave (
        input  line_read, line_write, line_address, line_wdata, mem_rdata, mem_resp,
        output line_rdata, line_resp, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output line_read, line_write, line_address, line_wdata, mem_rdata, mem_resp,
        input  line_rdata, line_resp, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/line_burst_adapter.sv
// Serializes whole-line fills/writebacks into fixed-length beat bursts on a narrower memory bus.
// S_LINE / S_BURST is expected to be a power of two of at least 2.
module line_burst_adapter #(
    parameter int S_LINE   = 256,
    parameter int S_BURST  = 64,
    parameter int S_OFFSET = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    line_burst_adapter_if.slave  bus
);
    localparam int BURST_LEN = S_LINE / S_BURST;
    localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [S_LINE-1:0]   r_wbuf;
    logic [S_LINE-1:0]   r_line_rdata;
    logic [31:0]         r_addr;
    logic [31:0]         w_addr_aligned;
    logic [S_BURST-1:0]  r_mem_wdata;
    logic                r_line_resp;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                w_last;
    logic                w_in_burst;
    logic                w_nxt_read;
    logic                w_nxt_write;
    logic                w_nxt_resp;
    logic                w_unused_offset;

    assign w_addr_aligned  = {bus.line_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
    assign w_unused_offset = ^bus.line_address[S_OFFSET-1:0];
    assign w_last          = (r_cnt == CNT_W'(BURST_LEN - 1));
    assign w_cnt_inc       = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_in_burst      = (r_state == RD_BURST) || (r_state == WR_BURST);

    // Next-state decode plus the control outputs that the state being entered will drive.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.line_write) begin
                    w_next = WR_BURST;
                end else if (bus.line_read) begin
                    w_next = RD_BURST;
                end else begin
                    w_next = IDLE;
                end
            end
            RD_BURST, WR_BURST: begin
                if (bus.mem_resp && w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = r_state;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_nxt_read  = (w_next == RD_BURST);
        w_nxt_write = (w_next == WR_BURST);
        w_nxt_resp  = (w_next == DONE);
    end

    // State register, beat counter and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_line_resp <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_mem_read  <= w_nxt_read;
            r_mem_write <= w_nxt_write;
            r_line_resp <= w_nxt_resp;
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (w_in_burst && bus.mem_resp) begin
                r_cnt <= w_cnt_inc;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Request capture, write-beat staging and fill assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbuf       <= '0;
            r_addr       <= 32'd0;
            r_mem_wdata  <= '0;
            r_line_rdata <= '0;
        end else begin
            if ((r_state == IDLE) && bus.line_write) begin
                r_wbuf      <= bus.line_wdata;
                r_addr      <= w_addr_aligned;
                r_mem_wdata <= bus.line_wdata[S_BURST-1:0];
            end else if ((r_state == IDLE) && bus.line_read) begin
                r_addr <= w_addr_aligned;
            end else if ((r_state == WR_BURST) && bus.mem_resp && !w_last) begin
                // Stage the following beat so mem_wdata comes straight from a flop.
                r_mem_wdata <= r_wbuf[int'(w_cnt_inc) * S_BURST +: S_BURST];
            end
            if ((r_state == RD_BURST) && bus.mem_resp) begin
                r_line_rdata[int'(r_cnt) * S_BURST +: S_BURST] <= bus.mem_rdata;
            end
        end
    end

    assign bus.line_rdata  = r_line_rdata;
    assign bus.line_resp   = r_line_resp;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_addr;
    assign bus.mem_wdata   = r_mem_wdata;
endmodule

// File: tb/tb_line_burst_adapter.sv
// Randomized bench for line_burst_adapter: each transaction's cycle schedule is derived from its
// mem_resp pattern, and one negedge process compares every output on every cycle.
module tb_line_burst_adapter;
    localparam int SL = 256;
    localparam int SB = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    line_burst_adapter_if #(.S_LINE(SL), .S_BURST(SB)) bus_if ();

    line_burst_adapter #(.S_LINE(SL), .S_BURST(SB), .S_OFFSET(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Current transaction schedule: request cycle s_c0, pattern index s_L holds the 4th accepted beat.
    bit             s_valid = 1'b0;
    bit             s_wr    = 1'b0;
    int             s_c0    = 0;
    int             s_L     = 0;
    logic [31:0]    s_addr  = 32'd0;
    logic [SL-1:0]  s_wline = '0;
    logic [SL-1:0]  s_rline = '0;
    logic [SL-1:0]  exp_hold = '0;
    bit             s_pat [0:63];
    int             resp_count = 0;
    int             last_resp_cyc = 0;
    logic [31:0]    seen_addr = 32'd0;
    logic [SB-1:0]  wbeats [$];

    task automatic chk(input string nm, input logic [SL-1:0] act, input logic [SL-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:5], 5'b00000};
    endfunction

    function automatic int ones_before(input int i);
        int n = 0;
        for (int j = 0; j < i; j++) if (s_pat[j]) n++;
        return n;
    endfunction

    function automatic int last_idx();
        int n = 0;
        for (int j = 0; j < 64; j++) begin
            if (s_pat[j]) n++;
            if (n == 4) return j;
        end
        return 63;
    endfunction

    function automatic logic [SL-1:0] partial(input int nb);
        logic [SL-1:0] v = exp_hold;
        for (int j = 0; j < nb; j++) v[j*SB +: SB] = s_rline[j*SB +: SB];
        return v;
    endfunction

    function automatic logic [SB-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [SL-1:0] rand256();
        logic [SL-1:0] v;
        for (int j = 0; j < SL/32; j++) v[j*32 +: 32] = $urandom();
        return v;
    endfunction

    // Compare every output against the schedule of the transaction in flight.
    always @(negedge clk) begin
        int i;
        int nb;
        if (rst) begin
            exp_hold = '0;
            chk("rst_line_rdata", bus_if.line_rdata, '0);
            chk("rst_line_resp", {255'd0, bus_if.line_resp}, '0);
            chk("rst_mem_read", {255'd0, bus_if.mem_read}, '0);
            chk("rst_mem_write", {255'd0, bus_if.mem_write}, '0);
            chk("rst_mem_address", {224'd0, bus_if.mem_address}, '0);
            chk("rst_mem_wdata", {192'd0, bus_if.mem_wdata}, '0);
        end else if (s_valid && (cyc > s_c0) && (cyc <= s_c0 + 1 + s_L)) begin
            i  = cyc - s_c0 - 1;
            nb = ones_before(i);
            chk("burst_mem_read", {255'd0, bus_if.mem_read}, {255'd0, !s_wr});
            chk("burst_mem_write", {255'd0, bus_if.mem_write}, {255'd0, s_wr});
            chk("burst_mem_address", {224'd0, bus_if.mem_address}, {224'd0, align(s_addr)});
            chk("burst_line_resp", {255'd0, bus_if.line_resp}, '0);
            seen_addr = bus_if.mem_address;
            if (s_wr) begin
                chk("burst_mem_wdata", {192'd0, bus_if.mem_wdata}, {192'd0, s_wline[nb*SB +: SB]});
                chk("burst_wr_line_rdata", bus_if.line_rdata, exp_hold);
                if (bus_if.mem_resp) wbeats.push_back(bus_if.mem_wdata);
            end else begin
                chk("burst_rd_line_rdata", bus_if.line_rdata, partial(nb));
            end
        end else if (s_valid && (cyc == s_c0 + 2 + s_L)) begin
            if (!s_wr) exp_hold = s_rline;
            chk("done_line_resp", {255'd0, bus_if.line_resp}, {255'd0, 1'b1});
            chk("done_mem_read", {255'd0, bus_if.mem_read}, '0);
            chk("done_mem_write", {255'd0, bus_if.mem_write}, '0);
            chk("done_line_rdata", bus_if.line_rdata, exp_hold);
            if (bus_if.line_resp) begin
                resp_count++;
                last_resp_cyc = cyc;
            end
        end else begin
            chk("idle_line_resp", {255'd0, bus_if.line_resp}, '0);
            chk("idle_mem_read", {255'd0, bus_if.mem_read}, '0);
            chk("idle_mem_write", {255'd0, bus_if.mem_write}, '0);
            chk("idle_line_rdata", bus_if.line_rdata, exp_hold);
            if (bus_if.line_resp) resp_count++;
        end
    end

    task automatic spurious();
        bus_if.mem_resp  = ($urandom_range(0, 1) == 1);
        bus_if.mem_rdata = rand64();
    endtask

    task automatic set_pat_bits(input logic [15:0] b);
        for (int j = 0; j < 64; j++) s_pat[j] = (j < 16) ? b[j] : 1'b0;
    endtask

    task automatic set_pat_rand();
        for (int j = 0; j < 64; j++) s_pat[j] = (j >= 40) ? 1'b1 : ($urandom_range(0, 9) < 6);
    endtask

    task automatic idle(input int n);
        bus_if.line_read  = 1'b0;
        bus_if.line_write = 1'b0;
        for (int j = 0; j < n; j++) begin
            spurious();
            @(posedge clk); #1;
        end
    endtask

    // Entered just after an edge; returns in the first cycle after DONE with the request still held.
    task automatic run_txn(input bit wr, input bit rd_too, input logic [31:0] addr,
                           input logic [SL-1:0] wl, input logic [SL-1:0] rl);
        int k = 0;
        s_wr = wr; s_addr = addr; s_wline = wl; s_rline = rl;
        s_c0 = cyc; s_L = last_idx(); s_valid = 1'b1;
        bus_if.line_write   = wr;
        bus_if.line_read    = !wr || rd_too;
        bus_if.line_address = addr;
        bus_if.line_wdata   = wl;
        spurious();
        for (int i = 0; i <= s_L; i++) begin
            @(posedge clk); #1;
            bus_if.mem_resp = s_pat[i];
            if (s_pat[i]) begin
                bus_if.mem_rdata = rl[k*SB +: SB];
                k++;
            end else begin
                bus_if.mem_rdata = rand64();
            end
        end
        @(posedge clk); #1;
        spurious();
        @(posedge clk); #1;
    endtask

    initial begin
        int c;
        int r0;
        int first_resp;
        bit wr;
        logic [31:0] a;
        bus_if.line_read = 1'b0; bus_if.line_write = 1'b0;
        bus_if.line_address = 32'd0; bus_if.line_wdata = '0;
        bus_if.mem_resp = 1'b0; bus_if.mem_rdata = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Directed read, no stalls.
        set_pat_bits(16'h000F);
        c = cyc;
        run_txn(1'b0, 1'b0, 32'h0000_1234, rand256(),
                {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        chk("t1_line_rdata", bus_if.line_rdata,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        chk("t1_resp_latency", last_resp_cyc - c, 256'd5);
        chk("t1_mem_address", {224'd0, seen_addr}, 256'h1220);
        chk("t1_resp_count", resp_count, 256'd1);
        idle(3);

        // Directed write with stalls 1,0,0,1,1,0,1.
        set_pat_bits(16'b1011001);
        wbeats.delete();
        c = cyc;
        run_txn(1'b1, 1'b0, 32'h0000_2040,
                256'h0123_4567_89AB_CDEF_F0E1_D2C3_B4A5_9687_1122_3344_5566_7788_FEDC_BA98_7654_CDEF,
                rand256());
        chk("t2_resp_latency", last_resp_cyc - c, 256'd8);
        chk("t2_beat_count", wbeats.size(), 256'd4);
        if (wbeats.size() == 4) begin
            chk("t2_beat0", {192'd0, wbeats[0]}, 256'hFEDC_BA98_7654_CDEF);
            chk("t2_beat3", {192'd0, wbeats[3]}, 256'h0123_4567_89AB_CDEF);
        end
        chk("t2_rdata_held", bus_if.line_rdata,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        idle(2);

        // Simultaneous read and write: write first, then the held read.
        set_pat_rand();
        a = $urandom();
        run_txn(1'b1, 1'b1, a, rand256(), rand256());
        set_pat_rand();
        run_txn(1'b0, 1'b0, a, rand256(), rand256());
        idle(2);

        // Reset after two read beats.
        set_pat_bits(16'h000F);
        s_wr = 1'b0; s_addr = 32'h0000_3000; s_rline = rand256(); s_wline = '0;
        s_c0 = cyc; s_L = 3; s_valid = 1'b1;
        bus_if.line_read = 1'b1; bus_if.line_write = 1'b0; bus_if.line_address = s_addr;
        bus_if.mem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            bus_if.mem_resp  = 1'b1;
            bus_if.mem_rdata = s_rline[i*SB +: SB];
        end
        @(posedge clk); #1;
        rst = 1'b1; s_valid = 1'b0; bus_if.line_read = 1'b0; bus_if.mem_resp = 1'b0;
        #1;
        chk("t4_mem_read", {255'd0, bus_if.mem_read}, '0);
        chk("t4_line_rdata", bus_if.line_rdata, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        r0 = resp_count;
        set_pat_rand();
        run_txn(1'b0, 1'b0, $urandom(), rand256(), rand256());
        chk("t4_fresh_resp", resp_count - r0, 256'd1);

        // Spurious mem_resp while idle.
        r0 = resp_count;
        idle(10);
        chk("t5_no_resp", resp_count - r0, 256'd0);

        // Back-to-back reads.
        set_pat_bits(16'h000F);
        run_txn(1'b0, 1'b0, 32'h0000_0100, rand256(), rand256());
        first_resp = last_resp_cyc;
        run_txn(1'b0, 1'b0, 32'h0000_0200, rand256(), rand256());
        chk("t6_resp_spacing", last_resp_cyc - first_resp, 256'd6);
        chk("t6_addr", {224'd0, seen_addr}, 256'h200);
        idle(2);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            set_pat_rand();
            wr = ($urandom_range(0, 1) == 1);
            a  = $urandom();
            if (wr && ($urandom_range(0, 3) == 0)) begin
                run_txn(1'b1, 1'b1, a, rand256(), rand256());
                set_pat_rand();
                run_txn(1'b0, 1'b0, a, rand256(), rand256());
            end else begin
                run_txn(wr, 1'b0, a, rand256(), rand256());
            end
            c = $urandom_range(0, 2);
            if (c > 0) idle(c);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
